// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared states, width helpers and output saturation for the FC layer
package fc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BIAS,
        ST_MAC,
        ST_DRAIN,
        ST_OUT
    } state_t;

    localparam int SAT_W = 64;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int acc_width(input int dw, input int n_in);
        return 2 * dw + clog2(n_in) + 1;
    endfunction

    // Clamp to a dw-bit signed range, then optionally zero negatives.
    function automatic logic signed [SAT_W-1:0] sat_relu(
        input logic signed [SAT_W-1:0] v,
        input int                      dw,
        input logic                    relu
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        logic signed [SAT_W-1:0] r;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (v > hi)      r = hi;
        else if (v < lo) r = lo;
        else             r = v;
        if (relu && r < 0) r = '0;
        return r;
    endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// rtl/fc_mac_lane.sv - one output neuron: bias load, multiply-accumulate, scaled saturating output
module fc_mac_lane
    import fc_pkg::*;
#(
    parameter int DW   = 16,
    parameter int FRAC = 8,
    parameter int ACCW = 35
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic                 i_acc,
    input  logic                 i_out,
    input  logic                 i_relu,
    input  logic signed [DW-1:0] i_bias,
    input  logic signed [DW-1:0] i_fm,
    input  logic signed [DW-1:0] i_w,
    output logic        [DW-1:0] o_result
);

    logic signed [ACCW-1:0]  r_acc;
    logic        [DW-1:0]    r_result;
    logic signed [2*DW-1:0]  w_prod;
    logic signed [ACCW-1:0]  w_bias;
    logic signed [ACCW-1:0]  w_shift;
    logic signed [SAT_W-1:0] w_wide;
    logic        [DW-1:0]    w_sat;

    assign w_prod  = i_fm * i_w;
    assign w_bias  = ACCW'(i_bias) <<< FRAC;
    assign w_shift = r_acc >>> FRAC;
    assign w_wide  = SAT_W'(w_shift);
    assign w_sat   = DW'(sat_relu(w_wide, DW, i_relu));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            if (i_load)     r_acc <= w_bias;
            else if (i_acc) r_acc <= r_acc + ACCW'(w_prod);
            if (i_out)      r_result <= w_sat;
        end
    end

    assign o_result = r_result;

endmodule

// File: rtl/fc_layer.sv
// rtl/fc_layer.sv - sequencer and BRAM addressing for N_OUT parallel dot products of length N_IN
module fc_layer
    import fc_pkg::*;
#(
    parameter int N_IN   = 84,
    parameter int N_OUT  = 10,
    parameter int DW     = 16,
    parameter int FRAC   = 8,
    parameter int W_AW   = 10,
    parameter int B_AW   = 7,
    parameter int FM_AW  = 7,
    parameter int W_BASE = 0,
    parameter int B_BASE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  relu_en,
    output logic                  fm_en,
    output logic [FM_AW-1:0]      fm_addr,
    input  logic [DW-1:0]         fm_dout,
    output logic                  w_en,
    output logic [W_AW-1:0]       w_addr,
    input  logic [N_OUT*DW-1:0]   w_dout,
    output logic                  b_en,
    output logic [B_AW-1:0]       b_addr,
    input  logic [N_OUT*DW-1:0]   b_dout,
    output logic [N_OUT*DW-1:0]   result,
    output logic                  result_vld,
    output logic                  busy,
    output logic                  done
);

    localparam int ACCW = acc_width(DW, N_IN);
    localparam int KW   = clog2(N_IN) + 1;

    state_t          r_state;
    state_t          w_next;
    logic [KW-1:0]   r_k;
    logic            r_relu;
    logic            r_done;
    logic            r_bias_vld;
    logic            r_mac_vld;
    logic            w_accept;
    logic            w_mac;

    // A start landing on the done cycle is dropped, not queued.
    assign w_accept = (r_state == ST_IDLE) && start && !r_done;
    assign w_mac    = (r_state == ST_MAC);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next = ST_BIAS;
            ST_BIAS:  w_next = ST_MAC;
            ST_MAC:   if (r_k == KW'(N_IN - 1)) w_next = ST_DRAIN;
            ST_DRAIN: w_next = ST_OUT;
            ST_OUT:   w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_k        <= '0;
            r_relu     <= 1'b0;
            r_done     <= 1'b0;
            r_bias_vld <= 1'b0;
            r_mac_vld  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_k        <= w_mac ? r_k + KW'(1) : '0;
            r_done     <= (r_state == ST_OUT);
            r_bias_vld <= (r_state == ST_BIAS);
            r_mac_vld  <= w_mac;
            if (w_accept) r_relu <= relu_en;
        end
    end

    assign b_en       = (r_state == ST_BIAS);
    assign b_addr     = b_en ? B_AW'(B_BASE) : '0;
    assign fm_en      = w_mac;
    assign w_en       = w_mac;
    assign fm_addr    = w_mac ? FM_AW'(r_k) : '0;
    assign w_addr     = w_mac ? W_AW'(W_BASE) + W_AW'(r_k) : '0;
    assign done       = r_done;
    assign result_vld = r_done;
    assign busy       = (r_state != ST_IDLE) || r_done;

    // BRAM data arrives one cycle after its enable, hence the delayed strobes.
    for (genvar j = 0; j < N_OUT; j++) begin : g_lane
        fc_mac_lane #(
            .DW   (DW),
            .FRAC (FRAC),
            .ACCW (ACCW)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .i_load   (r_bias_vld),
            .i_acc    (r_mac_vld),
            .i_out    (r_state == ST_OUT),
            .i_relu   (r_relu),
            .i_bias   (b_dout[j*DW +: DW]),
            .i_fm     (fm_dout),
            .i_w      (w_dout[j*DW +: DW]),
            .o_result (result[j*DW +: DW])
        );
    end

endmodule

// File: tb/tb_fc_layer.sv
// tb/tb_fc_layer.sv - directed table-driven bench for fc_layer (N_IN=4/N_OUT=2 and N_IN=1/N_OUT=1 builds)
module tb_fc_layer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        relu_en = 1'b0;
    logic        fm_en, w_en, b_en, result_vld, busy, done;
    logic [6:0]  fm_addr, b_addr;
    logic [9:0]  w_addr;
    logic [15:0] fm_dout;
    logic [31:0] w_dout, b_dout, result;

    logic        start1 = 1'b0;
    logic        fm_en1, w_en1, b_en1, result_vld1, busy1, done1;
    logic [6:0]  fm_addr1, b_addr1;
    logic [9:0]  w_addr1;
    logic [15:0] fm_dout1, w_dout1, b_dout1, result1;

    logic [15:0] fm_mem [4];
    logic [31:0] w_mem  [4];
    logic [31:0] b_mem;
    int          n_fm_rd = 0;
    int          n_b_rd  = 0;
    int          n_done  = 0;
    int          total   = 0;
    int          bad     = 0;

    always #5 clk = ~clk;

    fc_layer #(.N_IN(4), .N_OUT(2), .DW(16), .FRAC(8)) dut (
        .clk(clk), .rst(rst), .start(start), .relu_en(relu_en),
        .fm_en(fm_en), .fm_addr(fm_addr), .fm_dout(fm_dout),
        .w_en(w_en), .w_addr(w_addr), .w_dout(w_dout),
        .b_en(b_en), .b_addr(b_addr), .b_dout(b_dout),
        .result(result), .result_vld(result_vld), .busy(busy), .done(done)
    );

    fc_layer #(.N_IN(1), .N_OUT(1), .DW(16), .FRAC(8)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .relu_en(1'b0),
        .fm_en(fm_en1), .fm_addr(fm_addr1), .fm_dout(fm_dout1),
        .w_en(w_en1), .w_addr(w_addr1), .w_dout(w_dout1),
        .b_en(b_en1), .b_addr(b_addr1), .b_dout(b_dout1),
        .result(result1), .result_vld(result_vld1), .busy(busy1), .done(done1)
    );

    always @(posedge clk) begin
        if (fm_en) fm_dout <= fm_mem[fm_addr[1:0]];
        if (w_en)  w_dout  <= w_mem[w_addr[1:0]];
        if (b_en)  b_dout  <= b_mem;
        if (fm_en1) fm_dout1 <= 16'h0200;
        if (w_en1)  w_dout1  <= 16'h0180;
        if (b_en1)  b_dout1  <= 16'h0010;
        if (rst && fm_en) n_fm_rd <= n_fm_rd + 1;
        if (rst && b_en)  n_b_rd  <= n_b_rd + 1;
        if (rst && done)  n_done  <= n_done + 1;
    end

    typedef struct {
        logic [3:0][15:0] fm;
        logic [15:0]      w0, w1, b0, b1;
        logic             relu;
        logic [15:0]      e0, e1;
        string            name;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load(input vec_t v);
        for (int k = 0; k < 4; k++) begin
            fm_mem[k] = v.fm[k];
            w_mem[k]  = {v.w1, v.w0};
        end
        b_mem   = {v.b1, v.b0};
        relu_en = v.relu;
    endtask

    // Start accepted at edge 0; cycle c is observed at the negedge after edge c-1.
    task automatic run(input vec_t v);
        load(v);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start   = 1'b0;
            relu_en = ~v.relu;
            chk({v.name, " done"}, done, c == 8);
            chk({v.name, " vld"},  result_vld, c == 8);
            chk({v.name, " busy"}, busy, c <= 8);
            chk({v.name, " b_en"}, b_en, c == 1);
            chk({v.name, " fm_en"}, fm_en, c >= 2 && c <= 5);
            chk({v.name, " w_en"},  w_en,  c >= 2 && c <= 5);
            if (c >= 2 && c <= 5) begin
                chk({v.name, " fm_addr"}, fm_addr, c - 2);
                chk({v.name, " w_addr"},  w_addr,  c - 2);
            end
            if (c == 8 || c == 10) chk({v.name, " result"}, result, {v.e1, v.e0});
        end
    endtask

    initial begin
        vecs[0] = '{fm: {16'h0, 16'h0, 16'h0, 16'h0}, w0: 16'h0100, w1: 16'h0100,
                    b0: 16'h0100, b1: 16'hFF00, relu: 1'b0, e0: 16'h0100, e1: 16'hFF00, name: "bias"};
        vecs[1] = '{fm: {16'h0, 16'h0, 16'h0, 16'h0}, w0: 16'h0100, w1: 16'h0100,
                    b0: 16'h0100, b1: 16'hFF00, relu: 1'b1, e0: 16'h0100, e1: 16'h0000, name: "bias_relu"};
        vecs[2] = '{fm: {16'h0400, 16'h0300, 16'h0200, 16'h0100}, w0: 16'h0100, w1: 16'h0080,
                    b0: 16'h0, b1: 16'h0, relu: 1'b0, e0: 16'h0A00, e1: 16'h0500, name: "dot"};
        vecs[3] = '{fm: {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}, w0: 16'h7FFF, w1: 16'h7FFF,
                    b0: 16'h0, b1: 16'h0, relu: 1'b0, e0: 16'h7FFF, e1: 16'h7FFF, name: "sat_hi"};
        vecs[4] = '{fm: {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}, w0: 16'h8000, w1: 16'h8000,
                    b0: 16'h0, b1: 16'h0, relu: 1'b0, e0: 16'h8000, e1: 16'h8000, name: "sat_lo"};
        vecs[5] = '{fm: {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}, w0: 16'h8000, w1: 16'h8000,
                    b0: 16'h0, b1: 16'h0, relu: 1'b1, e0: 16'h0000, e1: 16'h0000, name: "sat_relu"};
        vecs[6] = '{fm: {16'h0, 16'h0, 16'h0, 16'h0080}, w0: 16'hFFFF, w1: 16'h0001,
                    b0: 16'h0, b1: 16'h0, relu: 1'b0, e0: 16'hFFFF, e1: 16'h0000, name: "floor"};

        repeat (2) @(negedge clk);
        chk("rst result", result, 0);
        chk("rst busy", busy, 0);
        chk("rst enables", {fm_en, w_en, b_en, done, result_vld}, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) run(vecs[i]);

        // start held through the run, the done cycle and cycle 9: two runs, done at 8 and 17
        load(vecs[2]);
        n_fm_rd = 0; n_b_rd = 0; n_done = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 10) start = 1'b0;
            chk("hold done", done, c == 8 || c == 17);
        end
        chk("hold dones", n_done, 2);
        chk("hold fm reads", n_fm_rd, 8);
        chk("hold b reads", n_b_rd, 2);
        chk("hold result", result, 32'h0500_0A00);

        // asynchronous abort in cycle 4
        load(vecs[3]);
        n_done = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b0;
        #1;
        chk("abort result", result, 0);
        chk("abort busy", busy, 0);
        chk("abort outs", {fm_en, w_en, b_en, done, result_vld}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort no done", n_done, 0);
        run(vecs[2]);

        // N_IN=1 build
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start1 = 1'b0;
            chk("n1 done", done1, c == 5);
            chk("n1 fm_en", fm_en1, c == 2);
            chk("n1 busy", busy1, c <= 5);
            if (c == 5) chk("n1 result", result1, 16'h0310);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
